// File: rtl/alien_fleet_if.sv
`default_nettype none
// ============================================================================
//  Module      : alien_fleet_if
//  Description : Signal bundle between the alien fleet and the rest of the
//                game (player block, renderer, tick generator).
//                slave  modport : the alien fleet itself
//                master modport : whoever drives the fleet (player side / bench)
//  Signals     : i_enable          game tick strobe
//                i_start_debounced start pulse from player
//                i_bullet_x/_y     bullet column / row
//                i_bullet_flying   bullet active
//                o_hit             one-cycle kill pulse
//                o_clear_score     one-cycle pulse at game start
//                o_alive           alive bitmap, bit = row*COLS+col
//                o_fleet_x/_y      fleet top-left position
//                o_state           0 IDLE, 1 PLAYING, 2 WON, 3 LOST
//  Revision    : 1.0 - initial release
// ============================================================================
interface alien_fleet_if #(
    parameter int ROWS = 3,
    parameter int COLS = 8
) ();
    logic                   i_enable;
    logic                   i_start_debounced;
    logic [4:0]             i_bullet_x;
    logic [3:0]             i_bullet_y;
    logic                   i_bullet_flying;
    logic                   o_hit;
    logic                   o_clear_score;
    logic [ROWS*COLS-1:0]   o_alive;
    logic [4:0]             o_fleet_x;
    logic [3:0]             o_fleet_y;
    logic [1:0]             o_state;

    modport slave (
        input  i_enable, i_start_debounced, i_bullet_x, i_bullet_y, i_bullet_flying,
        output o_hit, o_clear_score, o_alive, o_fleet_x, o_fleet_y, o_state
    );

    modport master (
        output i_enable, i_start_debounced, i_bullet_x, i_bullet_y, i_bullet_flying,
        input  o_hit, o_clear_score, o_alive, o_fleet_x, o_fleet_y, o_state
    );
endinterface
`default_nettype wire

// File: rtl/alien_fleet.sv
`default_nettype none
// ============================================================================
//  Module      : alien_fleet
//  Description : Invader side of the game. Owns the alien alive bitmap, the
//                fleet position and its marching motion, detects bullet hits
//                and runs the game-state machine (idle/playing/won/lost).
//  Ports       : i_clk_36MHz  system clock
//                i_reset      synchronous reset, active low
//                bus          alien_fleet_if.slave (see interface header)
//  Options     : ALIEN_SPEEDUP_EN - when fewer than COLS aliens remain the
//                fleet steps twice as often (threshold STEP_TICKS>>1, min 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module alien_fleet #(
    parameter int ROWS       = 3,
    parameter int COLS       = 8,
    parameter int STEP_TICKS = 30,
    parameter int X_MAX      = 31,
    parameter int LAND_Y     = 14
) (
    input  wire logic       i_clk_36MHz,
    input  wire logic       i_reset,
    alien_fleet_if.slave    bus
);

    localparam int N_ALIENS = ROWS * COLS;
    localparam int IDX_W    = (N_ALIENS > 1) ? $clog2(N_ALIENS) : 1;
    localparam int TICK_W   = $clog2(STEP_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_WON     = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    state_t                 state_q;
    logic [N_ALIENS-1:0]    alive_q;
    logic [4:0]             fleet_x_q;
    logic [3:0]             fleet_y_q;
    logic                   dir_left_q;
    logic [TICK_W-1:0]      tick_q;
    logic                   lockout_q;
    logic                   hit_q;
    logic                   clear_q;

    // ------------------------------------------------------------------
    // Hit detection against the registered (pre-step) fleet position.
    // Differences are 6 bits wide: a bullet left of / above the fleet
    // yields a value >= 32, which can never pass the < COLS / < ROWS test.
    // ------------------------------------------------------------------
    logic [5:0]         w_dx;
    logic [5:0]         w_dy;
    logic               w_in_grid;
    logic [IDX_W-1:0]   w_cell;
    logic               w_hit;

    assign w_dx = {1'b0, bus.i_bullet_x} - {1'b0, fleet_x_q};
    assign w_dy = {2'b00, bus.i_bullet_y} - {2'b00, fleet_y_q};

    always_comb begin
        w_in_grid = bus.i_bullet_flying && !lockout_q
                 && (bus.i_bullet_x >= fleet_x_q) && (w_dx < 6'(COLS))
                 && (bus.i_bullet_y >= fleet_y_q) && (w_dy < 6'(ROWS));
        w_cell = '0;
        if (w_in_grid) begin
            w_cell = IDX_W'(int'(w_dy) * COLS + int'(w_dx));
        end
        w_hit = w_in_grid && alive_q[w_cell];
    end

    // ------------------------------------------------------------------
    // Landing: the lowest row that still holds a live alien decides.
    // ------------------------------------------------------------------
    logic [5:0] w_low_row;
    logic       w_landed;
    logic       w_all_dead;

    always_comb begin
        w_low_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (|alive_q[r*COLS +: COLS]) begin
                w_low_row = 6'(r);
            end
        end
    end

    assign w_landed   = (({2'b00, fleet_y_q} + w_low_row) >= 6'(LAND_Y));
    assign w_all_dead = ~|alive_q;

    // ------------------------------------------------------------------
    // Step threshold
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] w_thresh;

`ifdef ALIEN_SPEEDUP_EN
    localparam int CNT_W      = $clog2(N_ALIENS + 1);
    localparam int HALF_TICKS = ((STEP_TICKS >> 1) < 1) ? 1 : (STEP_TICKS >> 1);

    logic [CNT_W-1:0] w_live;

    always_comb begin
        w_live = '0;
        for (int i = 0; i < N_ALIENS; i++) begin
            w_live = w_live + CNT_W'(alive_q[i]);
        end
    end

    assign w_thresh = (w_live < CNT_W'(COLS)) ? TICK_W'(HALF_TICKS) : TICK_W'(STEP_TICKS);
`else
    assign w_thresh = TICK_W'(STEP_TICKS);
`endif

    // >= rather than == so a threshold that shrinks mid-count steps at once
    // instead of wrapping around.
    logic w_step;
    assign w_step = (tick_q >= (w_thresh - TICK_W'(1)));

    // ------------------------------------------------------------------
    // Next fleet position for a step. A drop never moves horizontally.
    // ------------------------------------------------------------------
    logic [4:0] fleet_x_d;
    logic [3:0] fleet_y_d;
    logic       dir_left_d;
    logic [3:0] w_y_drop;

    assign w_y_drop = (fleet_y_q == 4'hF) ? 4'hF : fleet_y_q + 4'd1;

    always_comb begin
        fleet_x_d  = fleet_x_q;
        fleet_y_d  = fleet_y_q;
        dir_left_d = dir_left_q;
        if (!dir_left_q) begin
            if (({1'b0, fleet_x_q} + 6'(COLS - 1)) == 6'(X_MAX)) begin
                fleet_y_d  = w_y_drop;
                dir_left_d = 1'b1;
            end else begin
                fleet_x_d = fleet_x_q + 5'd1;
            end
        end else begin
            if (fleet_x_q == 5'd0) begin
                fleet_y_d  = w_y_drop;
                dir_left_d = 1'b0;
            end else begin
                fleet_x_d = fleet_x_q - 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Game FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_36MHz) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            alive_q    <= '1;
            fleet_x_q  <= '0;
            fleet_y_q  <= '0;
            dir_left_q <= 1'b0;
            tick_q     <= '0;
            lockout_q  <= 1'b0;
            hit_q      <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            hit_q   <= 1'b0;
            clear_q <= 1'b0;

            // One kill per bullet: re-arm only once the bullet is gone.
            if (!bus.i_bullet_flying) begin
                lockout_q <= 1'b0;
            end

            case (state_q)
                ST_PLAYING: begin
                    if (w_all_dead) begin
                        state_q <= ST_WON;
                    end else if (w_landed) begin
                        state_q <= ST_LOST;
                    end else begin
                        if (w_hit) begin
                            hit_q           <= 1'b1;
                            lockout_q       <= 1'b1;
                            alive_q[w_cell] <= 1'b0;
                        end
                        if (bus.i_enable) begin
                            if (w_step) begin
                                tick_q     <= '0;
                                fleet_x_q  <= fleet_x_d;
                                fleet_y_q  <= fleet_y_d;
                                dir_left_q <= dir_left_d;
                            end else begin
                                tick_q <= tick_q + TICK_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    if (bus.i_start_debounced) begin
                        state_q    <= ST_PLAYING;
                        alive_q    <= '1;
                        fleet_x_q  <= '0;
                        fleet_y_q  <= '0;
                        dir_left_q <= 1'b0;
                        tick_q     <= '0;
                        lockout_q  <= 1'b0;
                        clear_q    <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.o_hit         = hit_q;
    assign bus.o_clear_score = clear_q;
    assign bus.o_alive       = alive_q;
    assign bus.o_fleet_x     = fleet_x_q;
    assign bus.o_fleet_y     = fleet_y_q;
    assign bus.o_state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alien_fleet.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alien_fleet
//  Description : Self-checking bench for alien_fleet. Directed scenarios
//                followed by a randomized phase, all compared every cycle
//                against a behavioural game model.
//  Options     : ALIEN_SPEEDUP_EN selects the faster step rule in the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alien_fleet;

    localparam int ROWS       = 3;
    localparam int COLS       = 8;
    localparam int STEP_TICKS = 30;
    localparam int X_MAX      = 31;
    localparam int LAND_Y     = 14;
    localparam int N          = ROWS * COLS;

    logic clk = 1'b0;
    logic rst_n;

    always #14 clk = ~clk;

    alien_fleet_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    alien_fleet #(
        .ROWS(ROWS), .COLS(COLS), .STEP_TICKS(STEP_TICKS),
        .X_MAX(X_MAX), .LAND_Y(LAND_Y)
    ) dut (
        .i_clk_36MHz (clk),
        .i_reset     (rst_n),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural game model
    // ------------------------------------------------------------------
    int           m_state;
    logic [N-1:0] m_alive;
    int           m_fx, m_fy, m_ticks;
    bit           m_left, m_lock, m_hit, m_clr;

    task automatic model_reset();
        m_state = 0; m_alive = '1; m_fx = 0; m_fy = 0; m_left = 0;
        m_ticks = 0; m_lock = 0; m_hit = 0; m_clr = 0;
    endtask

    function automatic int lowest_live_row(input logic [N-1:0] a);
        int low = -1;
        for (int r = 0; r < ROWS; r++)
            if (a[r*COLS +: COLS] != '0) low = r;
        return low;
    endfunction

    task automatic model_step();
        int bx, by, dx, dy, thr;
        int fx, fy, ticks, st;
        bit left, lock, hit, clr;
        logic [N-1:0] alive;
        if (!rst_n) begin
            model_reset();
            return;
        end
        bx = int'(bus.i_bullet_x); by = int'(bus.i_bullet_y);
        fx = m_fx; fy = m_fy; ticks = m_ticks; st = m_state; left = m_left;
        alive = m_alive; hit = 0; clr = 0;
        lock = bus.i_bullet_flying ? m_lock : 1'b0;
        if (m_state != 1) begin
            if (bus.i_start_debounced) begin
                st = 1; alive = '1; fx = 0; fy = 0; left = 0; ticks = 0; lock = 0; clr = 1;
            end
        end else if (m_alive == '0) begin
            st = 2;
        end else if (m_fy + lowest_live_row(m_alive) >= LAND_Y) begin
            st = 3;
        end else begin
            dx = bx - m_fx;
            dy = by - m_fy;
            if (bus.i_bullet_flying && !m_lock && dx >= 0 && dx < COLS && dy >= 0 && dy < ROWS) begin
                if (m_alive[dy*COLS + dx]) begin
                    hit = 1; lock = 1; alive[dy*COLS + dx] = 1'b0;
                end
            end
            if (bus.i_enable) begin
                thr = STEP_TICKS;
`ifdef ALIEN_SPEEDUP_EN
                if ($countones(m_alive) < COLS) thr = (STEP_TICKS / 2 < 1) ? 1 : STEP_TICKS / 2;
`endif
                ticks = m_ticks + 1;
                if (ticks >= thr) begin
                    ticks = 0;
                    if (!m_left) begin
                        if (m_fx + COLS - 1 == X_MAX) begin
                            fy = (m_fy < 15) ? m_fy + 1 : 15; left = 1;
                        end else fx = m_fx + 1;
                    end else begin
                        if (m_fx == 0) begin
                            fy = (m_fy < 15) ? m_fy + 1 : 15; left = 0;
                        end else fx = m_fx - 1;
                    end
                end
            end
        end
        m_state = st; m_alive = alive; m_fx = fx; m_fy = fy; m_ticks = ticks;
        m_left = left; m_lock = lock; m_hit = hit; m_clr = clr;
    endtask

    task automatic compare();
        check_eq("state", bus.o_state, m_state);
        check_eq("alive", bus.o_alive, m_alive);
        check_eq("fleet_x", bus.o_fleet_x, m_fx);
        check_eq("fleet_y", bus.o_fleet_y, m_fy);
        check_eq("hit", bus.o_hit, m_hit);
        check_eq("clear_score", bus.o_clear_score, m_clr);
    endtask

    // One clock: edge, advance model, sample 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        bus.i_enable = 0; bus.i_start_debounced = 0; bus.i_bullet_flying = 0;
        bus.i_bullet_x = '0; bus.i_bullet_y = '0;
    endtask

    task automatic restart();
        idle_inputs();
        rst_n = 0; cycle();
        rst_n = 1; bus.i_start_debounced = 1; cycle();
        bus.i_start_debounced = 0;
    endtask

    // Fire at (x,y) for one cycle, check the kill pulse, then drop the bullet.
    task automatic shoot(input int x, input int y, input bit exp_hit, input string tag);
        bus.i_bullet_x = 5'(x); bus.i_bullet_y = 4'(y); bus.i_bullet_flying = 1;
        cycle();
        check_eq(tag, bus.o_hit, exp_hit);
        bus.i_bullet_flying = 0;
        cycle();
    endtask

    task automatic run_while_playing(input int budget, input string tag);
        int n = 0;
        while (bus.o_state == 2'd1 && n < budget) begin
            cycle();
            n++;
        end
        check_eq(tag, (n < budget), 1'b1);
    endtask

    initial begin
        int cnt, x0;
        idle_inputs();
        model_reset();

        // Reset state
        rst_n = 0;
        repeat (2) cycle();
        check_eq("rst_state", bus.o_state, 0);
        check_eq("rst_alive", bus.o_alive, 24'hFFFFFF);
        check_eq("rst_pos", {bus.o_fleet_x, bus.o_fleet_y}, 0);
        rst_n = 1;
        cycle();

        // Start: clear pulse for exactly one cycle
        bus.i_start_debounced = 1; cycle(); bus.i_start_debounced = 0;
        check_eq("start_clr", bus.o_clear_score, 1);
        check_eq("start_state", bus.o_state, 1);
        check_eq("start_alive", bus.o_alive, 24'hFFFFFF);
        check_eq("start_pos", {bus.o_fleet_x, bus.o_fleet_y}, 0);
        cycle();
        check_eq("clr_one_cycle", bus.o_clear_score, 0);

        // Marching: 24 steps right, drop, then left
        bus.i_enable = 1;
        repeat (720) cycle();
        check_eq("march_x24", bus.o_fleet_x, 24);
        check_eq("march_y0", bus.o_fleet_y, 0);
        repeat (30) cycle();
        check_eq("drop_x", bus.o_fleet_x, 24);
        check_eq("drop_y", bus.o_fleet_y, 1);
        repeat (30) cycle();
        check_eq("left_x", bus.o_fleet_x, 23);
        bus.i_enable = 0;

        // Hits and lockout
        restart();
        bus.i_bullet_x = 5'd3; bus.i_bullet_y = 4'd2; bus.i_bullet_flying = 1;
        cycle();
        check_eq("hit_3_2", bus.o_hit, 1);
        check_eq("bit19_dead", bus.o_alive[19], 0);
        bus.i_bullet_y = 4'd1;
        cycle();
        check_eq("lockout_no_hit", bus.o_hit, 0);
        check_eq("bit11_alive", bus.o_alive[11], 1);
        bus.i_bullet_flying = 0; cycle();
        shoot(3, 1, 1, "refire_3_1");
        check_eq("bit11_dead", bus.o_alive[11], 0);

        // Misses
        shoot(8, 0, 0, "miss_outside");
        shoot(2, 0, 1, "kill_2_0");
        shoot(2, 0, 0, "dead_cell");

        // Clear the board -> WON one cycle after the last kill
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (m_alive[r*COLS + c]) begin
                    if ($countones(m_alive) == 1) begin
                        bus.i_bullet_x = 5'(c); bus.i_bullet_y = 4'(r); bus.i_bullet_flying = 1;
                        cycle();
                        check_eq("last_hit", bus.o_hit, 1);
                        check_eq("last_alive", bus.o_alive, 0);
                        check_eq("still_playing", bus.o_state, 1);
                        bus.i_bullet_flying = 0;
                        cycle();
                        check_eq("won", bus.o_state, 2);
                    end else begin
                        shoot(c, r, 1, "kill_all");
                    end
                end
            end
        end
        bus.i_start_debounced = 1; cycle(); bus.i_start_debounced = 0;
        check_eq("restart_alive", bus.o_alive, 24'hFFFFFF);
        check_eq("restart_clr", bus.o_clear_score, 1);
        check_eq("restart_state", bus.o_state, 1);

        // Landing with all rows alive
        bus.i_enable = 1;
        run_while_playing(12000, "lost_full_timeout");
        check_eq("lost_full_state", bus.o_state, 3);
        check_eq("lost_full_y", bus.o_fleet_y, 12);
        bus.i_enable = 0;

        // Landing with bottom row gone
        restart();
        for (int c = 0; c < COLS; c++) shoot(c, 2, 1, "kill_row2");
        bus.i_enable = 1;
        run_while_playing(12000, "lost_row2_timeout");
        check_eq("lost_row2_state", bus.o_state, 3);
        check_eq("lost_row2_y", bus.o_fleet_y, 13);
        bus.i_enable = 0;

        // Step interval with seven aliens left
        restart();
        for (int r = 1; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) shoot(c, r, 1, "kill_rows");
        shoot(0, 0, 1, "kill_0_0");
        bus.i_enable = 1;
        cnt = 0;
        x0  = int'(bus.o_fleet_x);
        while (int'(bus.o_fleet_x) == x0 && cnt < 100) begin
            cycle();
            cnt++;
        end
`ifdef ALIEN_SPEEDUP_EN
        check_eq("step_interval", cnt, 15);
`else
        check_eq("step_interval", cnt, 30);
`endif
        bus.i_enable = 0;

        // Randomized play
        restart();
        for (int i = 0; i < 6000; i++) begin
            rst_n                 = ($urandom_range(0, 399) != 0);
            bus.i_start_debounced = ($urandom_range(0, 39) == 0);
            bus.i_enable          = ($urandom_range(0, 3) != 0);
            bus.i_bullet_flying   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) begin
                bus.i_bullet_x = 5'(m_fx + int'($urandom_range(0, COLS - 1)));
                bus.i_bullet_y = 4'(m_fy + int'($urandom_range(0, ROWS - 1)));
            end else begin
                bus.i_bullet_x = 5'($urandom_range(0, 31));
                bus.i_bullet_y = 4'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
